// File: rtl/fsm_seq_multi.sv
// fsm_seq_multi: CH independent synchronised + debounced IDLE->START->STOP->CLEAR sequencers.
// Optional per-channel abort timer: define FSM_TIMEOUT_EN.
module fsm_seq_chan #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             a,
    input  logic             en,
    input  logic             clr,
    output logic             k1,
    output logic             k2,
    output logic             tout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] count
);
    typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, STOP = 2'b10, CLEAR = 2'b11} state_t;
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic [1:0]      sync;
    logic            a_f;
    logic [DB_W-1:0] db_cnt;
    state_t          st, st_n;
    logic            adv, k1_n, k2_n, tout_n;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync   <= '0;
            a_f    <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync <= {sync[0], a};
            if (sync[1] == a_f)
                db_cnt <= '0;
            else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                a_f    <= sync[1];
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef FSM_TIMEOUT_EN
    localparam int TM_W = $clog2(TIMEOUT + 1);
    logic [TM_W-1:0] tmr;

    always_ff @(posedge Clock) begin
        if (!Reset || !en || st == IDLE || st_n != st)
            tmr <= '0;
        else
            tmr <= tmr + 1'b1;
    end
`endif

    // IDLE and STOP advance on a_f=1, START and CLEAR on a_f=0
    always_comb begin
        st_n   = st;
        k1_n   = 1'b0;
        k2_n   = 1'b0;
        tout_n = 1'b0;
        adv    = en && (a_f == ~st[0]);
        if (adv) begin
            st_n = state_t'(st + 2'd1);
            k2_n = (st == STOP);
            k1_n = (st == CLEAR);
        end
`ifdef FSM_TIMEOUT_EN
        else if (en && st != IDLE && tmr == TM_W'(TIMEOUT)) begin
            st_n   = IDLE;
            tout_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            st    <= IDLE;
            k1    <= 1'b0;
            k2    <= 1'b0;
            tout  <= 1'b0;
            count <= '0;
        end else begin
            st   <= st_n;
            k1   <= k1_n;
            k2   <= k2_n;
            tout <= tout_n;
            if (clr)
                count <= '0;
            else if (k1_n)
                count <= count + 1'b1;
        end
    end

    assign state = st;
endmodule

module fsm_seq_multi #(
    parameter int CH        = 2,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [CH-1:0]       A,
    input  logic [CH-1:0]       En,
    input  logic                Clr,
    output logic [CH-1:0]       K1,
    output logic [CH-1:0]       K2,
    output logic [2*CH-1:0]     State,
    output logic [CNT_W*CH-1:0] Count,
    output logic [CH-1:0]       Tout
);
    for (genvar i = 0; i < CH; i++) begin : g_ch
        fsm_seq_chan #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_ch (
            .Clock (Clock),
            .Reset (Reset),
            .a     (A[i]),
            .en    (En[i]),
            .clr   (Clr),
            .k1    (K1[i]),
            .k2    (K2[i]),
            .tout  (Tout[i]),
            .state (State[2*i +: 2]),
            .count (Count[CNT_W*i +: CNT_W])
        );
    end
endmodule

// File: tb/tb_fsm_seq_multi.sv
// Randomised + directed bench for fsm_seq_multi against a phase-counting reference model.
module tb_fsm_seq_multi;
    localparam int CH = 2, DB = 3, CW = 4, TO = 20;

    logic              Clock = 1'b0;
    logic              Reset, Clr;
    logic [CH-1:0]     A, En, K1, K2, Tout;
    logic [2*CH-1:0]   State;
    logic [CW*CH-1:0]  Count;

    int n_cmp = 0, n_err = 0;
    int m_s1[CH], m_s2[CH], m_af[CH], m_db[CH], m_ph[CH], m_tmr[CH], m_cnt[CH];
    int m_k1[CH], m_k2[CH], m_to[CH];
    int k1s[CH], k2s[CH], tos[CH];
    bit auto_clr = 0;

    fsm_seq_multi #(.CH(CH), .DB_CYCLES(DB), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset), .A(A), .En(En), .Clr(Clr),
        .K1(K1), .K2(K2), .State(State), .Count(Count), .Tout(Tout)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Sequence phase 0..3 advances when the filtered level equals the level the phase waits for
    task automatic model_update();
        for (int c = 0; c < CH; c++) begin
            int naf, ndb, nph, ntm, want;
            bit adv;
            if (!Reset) begin
                m_s1[c] = 0; m_s2[c] = 0; m_af[c] = 0; m_db[c] = 0; m_ph[c] = 0;
                m_tmr[c] = 0; m_cnt[c] = 0; m_k1[c] = 0; m_k2[c] = 0; m_to[c] = 0;
                continue;
            end
            naf = m_af[c]; ndb = 0;
            if (m_s2[c] != m_af[c]) begin
                if (m_db[c] + 1 == DB) naf = m_s2[c];
                else ndb = m_db[c] + 1;
            end
            want = (m_ph[c] % 2 == 0) ? 1 : 0;
            adv = En[c] && (m_af[c] == want);
            nph = m_ph[c]; ntm = m_tmr[c];
            m_k1[c] = 0; m_k2[c] = 0; m_to[c] = 0;
            if (adv) begin
                nph = (m_ph[c] + 1) % 4;
                m_k2[c] = (nph == 3);
                m_k1[c] = (nph == 0);
            end
`ifdef FSM_TIMEOUT_EN
            if (!En[c] || m_ph[c] == 0 || adv) ntm = 0;
            else if (m_tmr[c] == TO) begin nph = 0; m_to[c] = 1; ntm = 0; end
            else ntm = m_tmr[c] + 1;
`endif
            if (Clr) m_cnt[c] = 0;
            else if (m_k1[c] != 0) m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
            m_s2[c] = m_s1[c]; m_s1[c] = A[c];
            m_af[c] = naf; m_db[c] = ndb; m_ph[c] = nph; m_tmr[c] = ntm;
        end
    endtask

    task automatic step();
        if (auto_clr) Clr = (m_ph[1] == 3 && m_af[1] == 0 && En[1]);
        @(posedge Clock);
        model_update();
        #1;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("state%0d", c), int'(State[2*c +: 2]), m_ph[c]);
            chk($sformatf("count%0d", c), int'(Count[CW*c +: CW]), m_cnt[c]);
            chk($sformatf("k1_%0d", c), int'(K1[c]), m_k1[c]);
            chk($sformatf("k2_%0d", c), int'(K2[c]), m_k2[c]);
            chk($sformatf("tout%0d", c), int'(Tout[c]), m_to[c]);
            k1s[c] += int'(K1[c]); k2s[c] += int'(K2[c]); tos[c] += int'(Tout[c]);
        end
    endtask

    task automatic hold(input int ch, input logic v, input int n);
        A[ch] = v;
        repeat (n) step();
    endtask

    task automatic clr_tally();
        for (int c = 0; c < CH; c++) begin k1s[c] = 0; k2s[c] = 0; tos[c] = 0; end
    endtask

    task automatic do_reset(input logic [CH-1:0] a_val);
        Reset = 1'b0; A = a_val; En = '1; Clr = 1'b0;
        step(); step();
        Reset = 1'b1;
    endtask

    initial begin
        int hold_left[CH];
        // Reset with inputs high: both channels reach START on the 6th edge after release
        do_reset(2'b11);
        chk("rst_state", int'(State), 0);
        chk("rst_count", int'(Count), 0);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) chk("pre_start", int'(State[1:0]), 0);
        end
        chk("start6", int'(State[1:0]), 1);

        // Full sequence on ch0 only
        do_reset(2'b00);
        clr_tally();
        hold(0, 1, 10); hold(0, 0, 10); hold(0, 1, 10); hold(0, 0, 10);
        chk("seq_k2", k2s[0], 1);
        chk("seq_k1", k1s[0], 1);
        chk("seq_cnt0", int'(Count[3:0]), 1);
        chk("seq_ch1", int'(State[3:2]), 0);

        // Short glitch rejected, DB-cycle pulse accepted
        hold(0, 1, 2); hold(0, 0, 10);
        chk("glitch", int'(State[1:0]), 0);
        hold(0, 1, 3); hold(0, 0, 3);
        chk("pulse3", int'(State[1:0]), 1);
        hold(0, 0, 10); hold(0, 1, 10); hold(0, 0, 10);
        chk("pulse3_cnt", int'(Count[3:0]), 2);

        // Enable freeze in STOP
        hold(0, 1, 10); hold(0, 0, 10);
        En[0] = 1'b0;
        hold(0, 1, 10);
        chk("frz_stop", int'(State[1:0]), 2);
        En[0] = 1'b1;
        step();
        chk("frz_clear", int'(State[1:0]), 3);
        chk("frz_k2", int'(K2[0]), 1);
        hold(0, 0, 10);

        // Counter wrap on ch1, then clear on the same edge as K1
        for (int s = 0; s < 16; s++) begin
            hold(1, 1, 10); hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10);
        end
        chk("wrap", int'(Count[7:4]), 0);
        hold(1, 1, 10); hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10);
        chk("post_wrap", int'(Count[7:4]), 1);
        clr_tally();
        auto_clr = 1;
        hold(1, 1, 10); hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10);
        auto_clr = 0; Clr = 1'b0;
        chk("clr_k1", k1s[1], 1);
        chk("clr_cnt", int'(Count[7:4]), 0);

        // Park ch0 in START
        do_reset(2'b00);
        clr_tally();
        hold(0, 1, 6 + 40);
        chk("to_k1", k1s[0], 0);
        chk("to_cnt", int'(Count[3:0]), 0);
`ifdef FSM_TIMEOUT_EN
        chk("to_seen", int'(tos[0] > 0), 1);
`else
        chk("to_seen", tos[0], 0);
        chk("to_hold", int'(State[1:0]), 1);
`endif

        // Random traffic
        for (int c = 0; c < CH; c++) hold_left[c] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold_left[c] == 0) begin
                    A[c] = ~A[c];
                    hold_left[c] = $urandom_range(1, 14);
                end
                hold_left[c]--;
                if ($urandom_range(0, 19) == 0) En[c] = ~En[c];
                if (En[c] == 1'b0 && $urandom_range(0, 3) == 0) En[c] = 1'b1;
            end
            Clr = ($urandom_range(0, 39) == 0);
            Reset = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
